// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the word-oriented UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} tx_state_t;
  localparam int FRAME_DATA_BITS = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam logic MODE_BYTE = 1'b0;
  localparam logic MODE_WORD = 1'b1;
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction
endpackage

// File: rtl/uart_word_fifo.sv
// uart_word_fifo: synchronous FIFO with registered full/level; storage is unreset RAM.
module uart_word_fifo #(
  parameter int W  = 33,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic [AW:0]   o_level
);
  localparam int DEPTH = 1 << AW;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_level, w_level_nxt;
  logic r_full, w_push, w_pop;
  // a push is refused while full even if a pop frees a slot this cycle
  assign w_push = i_push && !r_full;
  assign w_pop = i_pop && (r_level != '0);
  assign w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign o_data = r_mem[r_rd_ptr];
  assign o_full = r_full;
  assign o_level = r_level;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full <= (w_level_nxt == (AW+1)'(DEPTH));
    end
  end
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: FIFO-buffered 8N1 UART transmitter; word entries go out MSB byte first.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 520,
  parameter int FIFO_AW = 6
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_en,
  input  logic [31:0]        wr_data,
  input  logic               wr_word,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               busy,
  output logic               overflow,
  output logic [31:0]        sent_count,
  output logic               txd
);
  localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
  localparam int TW = $clog2(BIT_CLKS);
  tx_state_t r_state, w_state_nxt;
  logic [TW-1:0] r_tmr;
  logic [2:0] r_bit_idx;
  logic [1:0] r_byte_idx;
  logic [31:0] r_shadow, r_sent;
  logic r_over, w_tick, w_pop;
  logic [32:0] w_head;
  logic [7:0] w_byte;
  assign w_tick = (r_tmr == TW'(BIT_CLKS - 1));
  assign w_pop = (r_state == LOAD);
  assign w_byte = byte_sel(r_shadow, r_byte_idx);
  uart_word_fifo #(.W(33), .AW(FIFO_AW)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .i_push(wr_en),
    .i_data({wr_word, wr_data}),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_full(full),
    .o_level(level)
  );
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (level != '0) w_state_nxt = LOAD;
      LOAD:  w_state_nxt = START;
      START: if (w_tick) w_state_nxt = DATA;
      DATA:  if (w_tick && r_bit_idx == 3'(FRAME_DATA_BITS - 1)) w_state_nxt = STOP;
      STOP:  if (w_tick) w_state_nxt = (r_byte_idx != '0) ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_tmr <= '0;
      r_bit_idx <= '0;
      r_byte_idx <= '0;
      r_shadow <= '0;
      r_sent <= '0;
      r_over <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr <= (r_state inside {START, DATA, STOP} && !w_tick) ? r_tmr + 1'b1 : '0;
      if (r_state == DATA && w_tick) r_bit_idx <= r_bit_idx + 1'b1;
      else if (r_state != DATA) r_bit_idx <= '0;
      if (r_state == LOAD) begin
        r_shadow <= w_head[31:0];
        r_byte_idx <= (w_head[32] == MODE_WORD) ? 2'(BYTES_PER_WORD - 1) : 2'd0;
      end
      // back-to-back bytes of one word skip IDLE/LOAD
      if (r_state == STOP && w_tick && r_byte_idx != '0) r_byte_idx <= r_byte_idx - 1'b1;
      if (r_state == STOP && w_tick && r_byte_idx == '0) r_sent <= r_sent + 32'd1;
      if (wr_en && full) r_over <= 1'b1;
    end
  end
  assign txd = (r_state == START) ? 1'b0 : (r_state == DATA) ? w_byte[r_bit_idx] : 1'b1;
  assign busy = (r_state != IDLE) || (level != '0);
  assign overflow = r_over;
  assign sent_count = r_sent;
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: randomized and directed checks of uart_word_tx against a timeline model.
module tb_uart_word_tx;
  localparam int CPH = 4;
  localparam int BC = 2 * CPH;
  localparam int DEPTH = 64;
  logic clk = 0, rstn = 0, wr_en = 0, wr_word = 0;
  logic [31:0] wr_data = 0;
  logic full, busy, overflow, txd;
  logic [6:0] level;
  logic [31:0] sent_count;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  uart_word_tx #(.CLK_PER_HALF_BIT(CPH), .FIFO_AW(6)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .wr_word(wr_word),
    .full(full), .level(level), .busy(busy), .overflow(overflow),
    .sent_count(sent_count), .txd(txd)
  );
  // Model: each entry owns a time slot; start edge = max(push edge, end of previous) + 2.
  int e = 0, f = 0, s_e = 0, end_e = 0, m_level = 0;
  bit m_act = 0, m_full = 0, m_over = 0, m_pop = 0, cw = 0;
  logic [31:0] cd = 0, m_sent = 0;
  bit qw[$];
  logic [31:0] qd[$];
  int qp[$];
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qw.delete(); qd.delete(); qp.delete();
      m_act = 0; m_level = 0; m_full = 0; m_over = 0; m_sent = 0; f = e;
    end else begin
      e++;
      m_pop = 0;
      if (m_act && e == end_e) begin m_act = 0; f = e; m_sent++; end
      if (!m_act && qp.size() > 0 && e == ((qp[0] > f) ? qp[0] : f) + 2) begin
        cw = qw.pop_front(); cd = qd.pop_front(); void'(qp.pop_front());
        m_act = 1; s_e = e; end_e = e + 10 * BC * (cw ? 4 : 1); m_pop = 1;
      end
      if (wr_en) begin
        if (m_full) m_over = 1;
        else begin qw.push_back(wr_word); qd.push_back(wr_data); qp.push_back(e); m_level++; end
      end
      if (m_pop) m_level--;
      m_full = (m_level == DEPTH);
    end
  end
  function automatic logic exp_txd();
    int k, b, pos;
    logic [7:0] by;
    if (!m_act) return 1'b1;
    k = e - s_e;
    b = k / (10 * BC);
    pos = (k % (10 * BC)) / BC;
    by = 8'(cd >> (cw ? 8 * (3 - b) : 0));
    return (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : by[pos-1];
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rstn) begin
      chk("txd", txd, exp_txd());
      chk("level", level, m_level);
      chk("full", full, m_full);
      chk("busy", busy, (m_level != 0) || m_act);
      chk("overflow", overflow, m_over);
      chk("sent_count", sent_count, m_sent);
    end
  end
  logic lg[0:799];
  logic [31:0] sc[0:799];
  logic bz[0:799];
  task automatic push(input logic w, input logic [31:0] d);
    wr_en = 1; wr_word = w; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic capture(input int n);
    for (int j = 0; j < n; j++) begin
      lg[j] = txd; sc[j] = sent_count; bz[j] = busy;
      @(negedge clk);
    end
  endtask
  function automatic logic [7:0] dec(input int s);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = lg[s + BC * (i + 1) + BC / 2];
    return d;
  endfunction
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40000) begin @(negedge clk); n++; end
    chk("drain_timeout", busy, 1'b0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_sent", sent_count, 0);
    rstn = 1;
    @(negedge clk);
    push(1, 32'hA1B2C3D4);
    capture(330);
    chk("w_pre_start", lg[1], 1'b1);
    chk("w_start", lg[2], 1'b0);
    chk("w_b0", dec(2), 8'hA1);
    chk("w_b1", dec(82), 8'hB2);
    chk("w_b2", dec(162), 8'hC3);
    chk("w_b3", dec(242), 8'hD4);
    chk("w_gapless_start", lg[82], 1'b0);
    chk("w_sent_before", sc[321], 0);
    chk("w_sent_after", sc[322], 1);
    chk("w_busy_drop", bz[322], 1'b0);
    push(0, 32'h12345678);
    capture(90);
    chk("b_byte", dec(2), 8'h78);
    chk("b_sent", sc[82], 2);
    chk("b_idle", lg[82], 1'b1);
    push(1, 32'h01020304);
    push(0, 32'h000000FF);
    push(1, 32'hDEADBEEF);
    capture(730);
    chk("m_01", dec(0), 8'h01);
    chk("m_02", dec(80), 8'h02);
    chk("m_03", dec(160), 8'h03);
    chk("m_04", dec(240), 8'h04);
    chk("m_gap0", lg[320], 1'b1);
    chk("m_gap1", lg[321], 1'b1);
    chk("m_ff", dec(322), 8'hFF);
    chk("m_de", dec(404), 8'hDE);
    chk("m_ad", dec(484), 8'hAD);
    chk("m_be", dec(564), 8'hBE);
    chk("m_ef", dec(644), 8'hEF);
    chk("m_sent", sc[724], 5);
    for (int i = 0; i < 66; i++) push(1, $urandom);
    chk("ov_flag", overflow, 1'b1);
    chk("ov_level", level, 64);
    chk("ov_full", full, 1'b1);
    wait_idle();
    push(0, 32'h11);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) push(0, 32'h20 + i);
    repeat (76) @(negedge clk);
    chk("pp_level_before", level, 5);
    wr_en = 1; wr_word = 0; wr_data = 32'h3C;
    @(negedge clk);
    wr_en = 0;
    chk("pp_level_after", level, 5);
    wait_idle();
    for (int i = 0; i < 4000; i++) begin
      wr_en = ($urandom_range(0, 39) == 0);
      wr_word = $urandom_range(0, 1);
      wr_data = $urandom;
      @(negedge clk);
    end
    wr_en = 0;
    wait_idle();
    push(0, 32'hA5);
    repeat (2 + BC * 3 + 2) @(negedge clk);
    #2 rstn = 0;
    #1;
    chk("ar_txd", txd, 1'b1);
    chk("ar_busy", busy, 1'b0);
    chk("ar_level", level, 0);
    chk("ar_sent", sent_count, 0);
    chk("ar_overflow", overflow, 1'b0);
    chk("ar_full", full, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    push(0, 32'h55);
    capture(90);
    chk("ar_start", lg[2], 1'b0);
    chk("ar_byte", dec(2), 8'h55);
    chk("ar_sent_after", sc[82], 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Transmit-side counterpart of the word-assembling UART receiver.
- Core pushes 32-bit words or single bytes into an internal FIFO. The block serializes them as 8N1 UART frames on txd.
- Word mode sends MSB byte first (bits 31:24 first), so the receiver rebuilds the identical word.
- Single clock domain. Replaces the edge-clocked write path with a proper synchronous write strobe plus backpressure.

Parameters:
- CLK_PER_HALF_BIT, 520: clocks per half UART bit; one bit period = 2*CLK_PER_HALF_BIT cycles.
- FIFO_AW, 6: FIFO address width; depth = 2**FIFO_AW entries (64).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- wr_en  in  1  push request, sampled on posedge clk
- wr_data  in  32  word or byte to send
- wr_word  in  1  1 = send all 4 bytes, 0 = send wr_data[7:0] only
- full  out  1  FIFO full; core must stall while high
- level  out  FIFO_AW+1  current FIFO occupancy
- busy  out  1  serializer active or FIFO non-empty
- overflow  out  1  sticky: a push was attempted while full
- sent_count  out  32  number of completed FIFO entries (word or byte)
- txd  out  1  UART serial output, idle high

Behaviour:
- Reset (async, rstn low): txd=1, full=0, level=0, busy=0, overflow=0, sent_count=0. FIFO pointers cleared. State returns to IDLE.
- Reset mid-frame aborts the frame immediately; txd goes high asynchronously.

FIFO
- Entry is {wr_word, wr_data}, 33 bits.
- Push when wr_en && !full. full and level are registered.
- Push while full is dropped and overflow is set; overflow clears only on reset.
- A push and a pop in the same cycle are both allowed; level stays the same.
- A push is rejected whenever full is high, even if a pop happens in that cycle.
- Pointers wrap modulo depth. full = (level == 2**FIFO_AW).

Serializer states: IDLE, LOAD, START, DATA, STOP.
- IDLE: if level != 0, go to LOAD; txd=1.
- LOAD (1 cycle): pop the head into a shadow register.
  - byte_idx = 3 if mode is word, otherwise 0.
  - Go to START.
- START: txd=0 for one bit period.
- DATA: 8 bits LSB first, one bit period each.
  - Current byte = shadow[8*byte_idx+7 : 8*byte_idx].
- STOP: txd=1 for one bit period. Then:
  - if byte_idx != 0: decrement byte_idx and go directly to START (no idle gap between bytes of one word);
  - else: increment sent_count and go to IDLE.
- Bit timer counts 0 .. 2*CLK_PER_HALF_BIT-1 and restarts on every bit boundary.
- Latency: a push into an empty FIFO at edge N gives txd low from edge N+2 (level visible at N+1, LOAD at N+1→N+2).
- Gap between consecutive entries: exactly 2 cycles of txd=1 after the stop bit (IDLE + LOAD).
- Word entry duration: 40 bit periods. Byte entry: 10 bit periods.
- busy = (state != IDLE) || (level != 0).
- sent_count wraps modulo 2**32.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, LOAD, START, DATA, STOP}
  - localparams FRAME_DATA_BITS=8, BYTES_PER_WORD=4, MODE_BYTE=1'b0, MODE_WORD=1'b1
- Sub-module uart_word_fifo: 33-bit synchronous FIFO with push/pop, full, level, and async active-low reset on pointers. Storage is inferred RAM, no reset.
- Top block holds the serializer FSM, bit timer, byte index, shadow register, and counters.

Test Plan (CLK_PER_HALF_BIT=4, so 8 cycles/bit):
- Push 0xA1B2C3D4 with wr_word=1 → four frames: 0xA1, 0xB2, 0xC3, 0xD4, in that order. Start bit begins 2 cycles after the push. No idle between frames. sent_count=1 after 320+2 cycles. busy then drops.
- Push 0x12345678 with wr_word=0 → a single frame carrying 0x78. sent_count=1. txd returns high.
- Push 65 words back-to-back with no pop possible yet → full=1 after the 64th push (or the 65th, if the first pop already occurred). Check that the dropped push sets overflow=1 and level never exceeds 64.
- Alternate pushes word, byte, word (0x01020304, 0xFF, 0xDEADBEEF) → byte stream 01 02 03 04 FF DE AD BE EF. Exactly 2 idle cycles between entries. sent_count=3.
- Push and pop in the same cycle while level=5 → level stays 5, with no lost or duplicated entry in the output stream.
- Assert rstn low in the middle of a DATA bit → txd=1 immediately and all outputs at reset values. After release, a new push of 0x55 (byte mode) transmits cleanly.
